// File: rtl/byte_sram_ctrl.sv
// byte_sram_ctrl: single-outstanding initiator for a 128x8 byte SRAM.
// Requests arrive on a valid/ready port and are sequenced onto the SRAM
// enable/index/data pins one access at a time. Read data returns on a
// valid/ready response port. Completed writes and reads are counted.
module byte_sram_ctrl #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              sram_clk,
    input  logic              sram_ares,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              wr_enable,
    output logic              rd_enable,
    output logic [ADDR_W-1:0] ram_index,
    output logic [DATA_W-1:0] sram_data_in,
    input  logic [DATA_W-1:0] sram_data_out,
    output logic [CNT_W-1:0]  wr_count,
    output logic [CNT_W-1:0]  rd_count
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WRITE   = 3'd1,
        RD_ADDR = 3'd2,
        RD_DATA = 3'd3,
        RSP     = 3'd4
    } state_t;

    state_t state, state_nxt;

    // req_ready is a registered copy of (state == IDLE), so this is the
    // true acceptance condition at the coming edge.
    logic accept;
    assign accept = req_valid && req_ready;

    // State register.
    always_ff @(posedge sram_clk or posedge sram_ares) begin
        if (sram_ares) state <= IDLE;
        else           state <= state_nxt;
    end

    // Next-state logic: one access in flight, reads wait in RSP for the client.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = req_write ? WRITE : RD_ADDR;
            WRITE:   state_nxt = IDLE;
            RD_ADDR: state_nxt = RD_DATA;
            RD_DATA: state_nxt = RSP;
            RSP:     if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Registered outputs, decoded from the next state so they line up with
    // the state they belong to. Only one enable can be set per state, so
    // wr_enable and rd_enable are never high together.
    always_ff @(posedge sram_clk or posedge sram_ares) begin
        if (sram_ares) begin
            req_ready <= 1'b1;
            wr_enable <= 1'b0;
            rd_enable <= 1'b0;
            rsp_valid <= 1'b0;
        end else begin
            req_ready <= (state_nxt == IDLE);
            wr_enable <= (state_nxt == WRITE);
            rd_enable <= (state_nxt == RD_ADDR) || (state_nxt == RD_DATA);
            rsp_valid <= (state_nxt == RSP);
        end
    end

    // Latch the request at acceptance; index/data hold afterwards.
    always_ff @(posedge sram_clk or posedge sram_ares) begin
        if (sram_ares) begin
            ram_index    <= '0;
            sram_data_in <= '0;
        end else if (state == IDLE && accept) begin
            ram_index <= req_addr;
            if (req_write) sram_data_in <= req_wdata;
        end
    end

    // Capture SRAM read data at the end of RD_DATA; held through RSP.
    always_ff @(posedge sram_clk or posedge sram_ares) begin
        if (sram_ares)              rsp_rdata <= '0;
        else if (state == RD_DATA)  rsp_rdata <= sram_data_out;
    end

    // Access counters, free-running with natural wrap.
    always_ff @(posedge sram_clk or posedge sram_ares) begin
        if (sram_ares) begin
            wr_count <= '0;
            rd_count <= '0;
        end else begin
            if (state == WRITE)             wr_count <= wr_count + 1'b1;
            if (state == RSP && rsp_ready)  rd_count <= rd_count + 1'b1;
        end
    end

endmodule
